// File: rtl/mult_seq_ctrl_n.sv
// Sequential shift-add multiplier with generic width and run-time signed/unsigned mode.
// Product {Aval,Bval} plus extension bit X is valid while Done is high.
module mult_seq_ctrl_n #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ClearA_LoadB,
  input  logic         Run,
  input  logic         Signed_Mode,
  input  logic [N-1:0] S,
  output logic [N-1:0] Aval,
  output logic [N-1:0] Bval,
  output logic         X,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    OP    = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  m_reg;
  logic          x_reg;
  logic          sm;
  logic [CW-1:0] cnt;

  logic [N:0]    a_ext;
  logic [N:0]    m_ext;
  logic [N:0]    sum;
  logic          last;

  assign last = (cnt == CW'(N - 1));

  // The final signed step subtracts: the multiplier MSB carries negative weight.
  always_comb begin
    a_ext = sm ? {a_reg[N-1], a_reg} : {1'b0, a_reg};
    m_ext = sm ? {m_reg[N-1], m_reg} : {1'b0, m_reg};
    sum   = (sm && last) ? (a_ext - m_ext) : (a_ext + m_ext);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      x_reg <= 1'b0;
      sm    <= 1'b0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= S;
          end else if (Run) begin
            state <= CLR;
            Busy  <= 1'b1;
          end
        end
        CLR: begin
          a_reg <= '0;
          x_reg <= 1'b0;
          m_reg <= S;
          sm    <= Signed_Mode;
          cnt   <= '0;
          state <= OP;
        end
        OP: begin
          if (b_reg[0]) begin
            x_reg <= sum[N];
            a_reg <= sum[N-1:0];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          b_reg <= {a_reg[0], b_reg[N-1:1]};
          a_reg <= {x_reg, a_reg[N-1:1]};
          x_reg <= sm ? x_reg : 1'b0;
          if (last) begin
            state <= DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
          end else begin
            cnt   <= cnt + CW'(1);
            state <= OP;
          end
        end
        DONE: begin
          if (!Run) begin
            state <= IDLE;
            Done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

  assign Aval = a_reg;
  assign Bval = b_reg;
  assign X    = x_reg;

endmodule
